scntr_arb_ctl: RTL and testbench
================================

# scntr_arb_ctl

Sequencing controller and round-robin arbiter that shares a single loadable up-counter (`scntr`-family datapath cell: D/PL/EN/PRE in, Q/COUT out) among `NREQ` requesters, each of which needs an interval timer for a programmable number of cycles. The block grants the counter to one requester at a time, loads it with the two's-complement of the requested length, enables counting until carry-out, then acknowledges and releases. It sits beside the counter in the datapath group and is the only driver of the counter's control pins.

## Interface
Parameters:
- `N`, 8, counter width, matches attached counter
- `NREQ`, 4, number of requesters, 2..8

Ports:
- `CLK`  in  1  rising-edge clock, shared with counter
- `RSTN`  in  1  synchronous active-low reset
- `REQ`  in  NREQ  per-requester request level
- `LDVAL`  in  NREQ*N  per-requester interval length, slice i = bits [i*N +: N]
- `GNT`  out  NREQ  one-hot owner indication, held LOAD through RUN
- `ACK`  out  NREQ  one-cycle completion pulse to owner
- `BUSY`  out  1  counter owned (state != IDLE)
- `CNT_D`  out  N  counter parallel-load data
- `CNT_PL`  out  1  counter parallel-load strobe
- `CNT_EN`  out  1  counter count enable
- `CNT_PRE`  out  1  counter preset/clear strobe
- `CNT_COUT`  in  1  counter carry-out (Q all-ones while EN)
- `CNT_Q`  in  N  counter value, monitored only under `SCNTR_ARB_ABORT_EN`

## Operation
- States: IDLE, LOAD, RUN, DONE; plus ABORT when the abort feature is compiled in.
- IDLE: if any `REQ` bit is set, the round-robin picker selects the first set bit at or above pointer `ptr`, wrapping. Register the owner, capture its `LDVAL` slice to `L`, go to LOAD.
- LOAD: `GNT[owner]`=1, `CNT_PL`=1, `CNT_D` = (2^N − L) mod 2^N. Go to RUN.
- RUN: `GNT[owner]`=1, `CNT_EN`=1. Stay until `CNT_COUT` is sampled high, then go to DONE.
- DONE: `ACK[owner]`=1, `GNT`=0, `CNT_EN`=0. Set `ptr` = owner+1 mod NREQ. Go to IDLE.
- `L`=0 means 2^N counting cycles. `CNT_D`=0 counts the full wrap.
- `REQ` of non-owners is ignored while BUSY. It is re-sampled in IDLE only.
- All outputs are decoded from registered state and owner. There is no combinational path from `REQ` or `CNT_COUT` to outputs.
- Reset (`RSTN`=0 at an edge): state IDLE, `ptr`=0, `GNT`=0, `ACK`=0, `BUSY`=0, `CNT_D`=0, `CNT_PL`=0, `CNT_EN`=0, `CNT_PRE`=0.
  - Reset mid-RUN abandons the owner with no `ACK`.
  - The counter value is left as-is; the next LOAD overwrites it.

## Timing
- `REQ` sampled at edge t: LOAD during cycle t+1, RUN during t+2 … t+1+L, DONE during t+2+L, IDLE during t+3+L.
- Total occupancy is L+2 cycles plus the IDLE arbitration cycle. Back-to-back grants are spaced L+3 cycles apart.
- `ACK` is exactly one cycle wide and coincides with `GNT` deassertion.
- A `REQ` held high after `ACK` is re-arbitrated. Because of the pointer advance, other pending requesters win first.

## Configuration
- `SCNTR_ARB_ABORT_EN` defined: if `REQ[owner]` is sampled low in LOAD or RUN, go to ABORT.
  - ABORT: `CNT_PRE`=1 for one cycle, `GNT`=0, no `ACK`, `ptr` = owner+1, then IDLE.
  - In ABORT, `CNT_Q` is ignored except by an assertion that it equals all-ones one cycle after ABORT.
- `SCNTR_ARB_ABORT_EN` undefined: `REQ[owner]` is ignored once granted. The interval always completes with `ACK`. `CNT_PRE` is tied 0 and the ABORT state does not exist.

## Structure
- Package `scntr_arb_pkg`: state enum, `N`/`NREQ` default constants, a helper function computing the load value (2^N − L).
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are `REQ` and `ptr`; outputs are a one-hot winner and its index. It is reusable by other shared-resource controllers.

## Test plan
- Reset: hold `RSTN`=0 three cycles with `REQ`=4'hF → all outputs 0, state IDLE. First grant after release goes to requester 0.
- Single request: `REQ`=4'b0010, `LDVAL[1]`=5 → `GNT`=4'b0010 for 6 cycles, `CNT_D`=8'hFB with `CNT_PL`, `CNT_EN` high 5 cycles, `ACK[1]` pulse at cycle t+7.
- Round-robin: `REQ`=4'b1011 held, all `LDVAL`=2 → grant order 0,1,3,0,1,3, each `ACK` spaced 5 cycles.
- Zero length: `LDVAL[2]`=0 → RUN lasts 256 cycles, `CNT_D`=8'h00, single `ACK`.
- Abort (macro on): `REQ[0]` dropped on RUN cycle 3 of L=10 → `CNT_PRE` pulses one cycle, no `ACK`, `BUSY` low next cycle. With the macro off, the interval completes and `ACK[0]` is asserted.
- Reset mid-RUN: `RSTN` low during RUN → `GNT`/`CNT_EN` 0 next cycle, no `ACK`. A fresh request afterwards completes normally.

Source files
------------

// File: rtl/scntr_arb_pkg.sv
// Shared types and helpers for the shared-counter arbiter family.
// SCNTR_ARB_ABORT_EN adds the ABORT state to the state enum.
package scntr_arb_pkg;

    localparam int N_DEF    = 8;
    localparam int NREQ_DEF = 4;

`ifdef SCNTR_ARB_ABORT_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ABORT = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3
    } state_t;
`endif

    // 2^N - L taken mod 2^N is the two's complement of L; callers truncate to N bits.
    function automatic logic [31:0] load_val(input logic [31:0] len);
        return 32'd0 - len;
    endfunction

endpackage

// File: rtl/scntr_arb_ctl_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
// o_gnt is one-hot (all zero when nothing is requested); o_idx is its index.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [PW-1:0]   o_idx
);

    logic [PW-1:0] w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        w_cand = '0;
        // Scan from furthest to nearest so the nearest hit to the pointer wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand = PW'((int'(i_ptr) + k) % NREQ);
            if (i_req[w_cand]) begin
                o_idx = w_cand;
            end
        end
        if (|i_req) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/scntr_arb_ctl.sv
// Round-robin owner of a shared loadable up-counter: loads -L, counts to carry-out, ACKs owner.
// Define SCNTR_ARB_ABORT_EN to abort (preset counter, no ACK) when the owner drops its request.
module scntr_arb_ctl
    import scntr_arb_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int NREQ = NREQ_DEF
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic [NREQ-1:0]   REQ,
    input  logic [NREQ*N-1:0] LDVAL,
    output logic [NREQ-1:0]   GNT,
    output logic [NREQ-1:0]   ACK,
    output logic              BUSY,
    output logic [N-1:0]      CNT_D,
    output logic              CNT_PL,
    output logic              CNT_EN,
    output logic              CNT_PRE,
    input  logic              CNT_COUT,
    input  logic [N-1:0]      CNT_Q
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_owner, w_owner_nxt;
    logic [PW-1:0]   r_ptr, w_ptr_nxt;
    logic [N-1:0]    r_len, w_len_nxt;
    logic [NREQ-1:0] w_pick_gnt;
    logic [PW-1:0]   w_pick_idx;
    logic [NREQ-1:0] w_owner_oh;
    logic [N-1:0]    w_ldval [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_ldval
        assign w_ldval[g] = LDVAL[g*N +: N];
    end

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_rr_pick (
        .i_req (REQ),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx)
    );

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_len   <= w_len_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_len_nxt   = r_len;
        case (r_state)
            ST_IDLE: begin
                if (|w_pick_gnt) begin
                    w_owner_nxt = w_pick_idx;
                    w_len_nxt   = w_ldval[w_pick_idx];
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_RUN;
`ifdef SCNTR_ARB_ABORT_EN
                if (!REQ[r_owner]) w_state_nxt = ST_ABORT;
`endif
            end
            ST_RUN: begin
                // Withdrawal takes precedence over a coincident carry-out.
`ifdef SCNTR_ARB_ABORT_EN
                if (!REQ[r_owner])  w_state_nxt = ST_ABORT;
                else if (CNT_COUT)  w_state_nxt = ST_DONE;
`else
                if (CNT_COUT) w_state_nxt = ST_DONE;
`endif
            end
            ST_DONE: begin
                w_ptr_nxt   = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
                w_state_nxt = ST_IDLE;
            end
`ifdef SCNTR_ARB_ABORT_EN
            ST_ABORT: begin
                w_ptr_nxt   = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
                w_state_nxt = ST_IDLE;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_owner_oh = NREQ'(1) << r_owner;

    always_comb begin
        GNT     = '0;
        ACK     = '0;
        CNT_D   = '0;
        CNT_PL  = 1'b0;
        CNT_EN  = 1'b0;
        CNT_PRE = 1'b0;
        BUSY    = (r_state != ST_IDLE);
        case (r_state)
            ST_LOAD: begin
                GNT    = w_owner_oh;
                CNT_PL = 1'b1;
                CNT_D  = N'(load_val(32'(r_len)));
            end
            ST_RUN: begin
                GNT    = w_owner_oh;
                CNT_EN = 1'b1;
            end
            ST_DONE: ACK = w_owner_oh;
`ifdef SCNTR_ARB_ABORT_EN
            ST_ABORT: CNT_PRE = 1'b1;
`endif
            default: ;
        endcase
    end

`ifdef SCNTR_ARB_ABORT_EN
    logic r_abort_q;

    always_ff @(posedge CLK) begin
        if (!RSTN) r_abort_q <= 1'b0;
        else       r_abort_q <= (r_state == ST_ABORT);
    end

    a_preset_ones: assert property (@(posedge CLK) disable iff (!RSTN)
        r_abort_q |-> (CNT_Q == '1));
`else
    logic w_unused_q;
    assign w_unused_q = ^CNT_Q;
`endif

endmodule

// File: tb/tb_scntr_arb_ctl.sv
// Directed bench for scntr_arb_ctl with a behavioural model of the attached counter.
// Abort expectations follow SCNTR_ARB_ABORT_EN as compiled.
module tb_scntr_arb_ctl;

    localparam int N    = 8;
    localparam int NREQ = 4;

    logic          CLK = 1'b0;
    logic          RSTN;
    logic [3:0]    REQ;
    logic [31:0]   LDVAL;
    logic [3:0]    GNT, ACK;
    logic          BUSY, CNT_PL, CNT_EN, CNT_PRE;
    logic [7:0]    CNT_D;
    logic [7:0]    cnt_q = 8'h00;
    logic          cnt_cout;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    // Counter model: preset to all-ones, parallel load, increment on enable.
    always @(posedge CLK) begin
        if (CNT_PRE)     cnt_q <= 8'hFF;
        else if (CNT_PL) cnt_q <= CNT_D;
        else if (CNT_EN) cnt_q <= cnt_q + 8'd1;
    end
    assign cnt_cout = CNT_EN && (cnt_q == 8'hFF);

    scntr_arb_ctl #(.N(N), .NREQ(NREQ)) dut (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .REQ      (REQ),
        .LDVAL    (LDVAL),
        .GNT      (GNT),
        .ACK      (ACK),
        .BUSY     (BUSY),
        .CNT_D    (CNT_D),
        .CNT_PL   (CNT_PL),
        .CNT_EN   (CNT_EN),
        .CNT_PRE  (CNT_PRE),
        .CNT_COUT (cnt_cout),
        .CNT_Q    (cnt_q)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        REQ  = 4'b0000;
        step();
        step();
        RSTN = 1'b1;
    endtask

    // Steps until ACK (or budget); REQ is dropped after the first (LOAD) cycle.
    task automatic run_until_ack(input int budget, output int c_ack, output int n_gnt,
                                 output int n_en, output logic [3:0] ack_v,
                                 output logic [3:0] gnt0, output logic [7:0] d0,
                                 output logic pl0);
        c_ack = -1; n_gnt = 0; n_en = 0; ack_v = 4'b0; gnt0 = 4'b0; d0 = 8'h0; pl0 = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            step();
            if (c == 1) begin
                gnt0 = GNT; d0 = CNT_D; pl0 = CNT_PL;
                REQ  = 4'b0000;
            end
            if (GNT != 4'b0) n_gnt++;
            if (CNT_EN) n_en++;
            if (ACK != 4'b0) begin
                c_ack = c; ack_v = ACK;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int c_ack, n_gnt, n_en; logic [3:0] ack_v, gnt0; logic [7:0] d0; logic pl0;
        RSTN = 1'b0; REQ = 4'hF; LDVAL = {4{8'd1}};
        step(); step(); step();
        checks++;
        if ({GNT, ACK, BUSY, CNT_D, CNT_PL, CNT_EN, CNT_PRE} !== 20'h0) begin
            failures++;
            $display("FAIL reset_outputs got gnt=%b ack=%b busy=%b d=%h pl=%b en=%b pre=%b want all 0",
                     GNT, ACK, BUSY, CNT_D, CNT_PL, CNT_EN, CNT_PRE);
        end
        RSTN = 1'b1;
        run_until_ack(20, c_ack, n_gnt, n_en, ack_v, gnt0, d0, pl0);
        checks++;
        if (gnt0 !== 4'b0001) begin
            failures++; $display("FAIL reset_first_gnt got=%b want=0001", gnt0);
        end
        checks++;
        if (c_ack != 3 || ack_v !== 4'b0001) begin
            failures++; $display("FAIL reset_first_ack got cycle=%0d ack=%b want cycle=3 ack=0001", c_ack, ack_v);
        end
        step();
    endtask

    task automatic test_single();
        int c_ack, n_gnt, n_en; logic [3:0] ack_v, gnt0; logic [7:0] d0; logic pl0;
        LDVAL = 32'h0000_0500; REQ = 4'b0010;
        run_until_ack(30, c_ack, n_gnt, n_en, ack_v, gnt0, d0, pl0);
        checks++;
        if (gnt0 !== 4'b0010 || pl0 !== 1'b1 || d0 !== 8'hFB) begin
            failures++; $display("FAIL single_load got gnt=%b pl=%b d=%h want 0010 1 fb", gnt0, pl0, d0);
        end
        checks++;
        if (n_gnt != 6 || n_en != 5) begin
            failures++; $display("FAIL single_len got gnt_cycles=%0d en_cycles=%0d want 6 5", n_gnt, n_en);
        end
        checks++;
        if (c_ack != 7 || ack_v !== 4'b0010) begin
            failures++; $display("FAIL single_ack got cycle=%0d ack=%b want 7 0010", c_ack, ack_v);
        end
        step();
        checks++;
        if (ACK !== 4'b0 || BUSY !== 1'b0) begin
            failures++; $display("FAIL single_ack_width got ack=%b busy=%b want 0000 0", ACK, BUSY);
        end
    endtask

    task automatic test_round_robin();
        int order[6]; int when[6]; int n;
        int exp_order[6] = '{0, 1, 3, 0, 1, 3};
        do_reset();
        n = 0;
        LDVAL = {4{8'd2}}; REQ = 4'b1011;
        for (int c = 1; c <= 60 && n < 6; c++) begin
            step();
            if (ACK != 4'b0) begin
                order[n] = 0;
                for (int b = 0; b < 4; b++) if (ACK[b]) order[n] = b;
                when[n] = c;
                n++;
            end
        end
        REQ = 4'b0000;
        step();
        checks++;
        if (n != 6) begin
            failures++; $display("FAIL rr_ack_count got=%0d want=6", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (order[i] != exp_order[i]) begin
                failures++; $display("FAIL rr_order[%0d] got=%0d want=%0d", i, order[i], exp_order[i]);
            end
        end
        if (n > 0) begin
            checks++;
            if (when[0] != 4) begin
                failures++; $display("FAIL rr_first_ack got cycle=%0d want=4", when[0]);
            end
        end
        for (int i = 1; i < n; i++) begin
            checks++;
            if (when[i] - when[i-1] != 5) begin
                failures++; $display("FAIL rr_spacing[%0d] got=%0d want=5", i, when[i] - when[i-1]);
            end
        end
    endtask

    task automatic test_zero_length();
        int c_ack, n_gnt, n_en; int extra_acks; logic [3:0] ack_v, gnt0; logic [7:0] d0; logic pl0;
        LDVAL = 32'h0000_0505; REQ = 4'b0100;
        run_until_ack(400, c_ack, n_gnt, n_en, ack_v, gnt0, d0, pl0);
        checks++;
        if (gnt0 !== 4'b0100 || d0 !== 8'h00) begin
            failures++; $display("FAIL zero_load got gnt=%b d=%h want 0100 00", gnt0, d0);
        end
        checks++;
        if (n_en != 256 || c_ack != 258 || ack_v !== 4'b0100) begin
            failures++; $display("FAIL zero_run got en=%0d ack_cycle=%0d ack=%b want 256 258 0100", n_en, c_ack, ack_v);
        end
        extra_acks = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (ACK != 4'b0) extra_acks++;
        end
        checks++;
        if (extra_acks != 0) begin
            failures++; $display("FAIL zero_single_ack got extra=%0d want=0", extra_acks);
        end
    endtask

    task automatic test_abort();
        int c_ack; int pre_seen;
        do_reset();
        LDVAL = 32'h0000_000A; REQ = 4'b0001;
        step(); step(); step(); step();
        checks++;
        if (GNT !== 4'b0001 || CNT_EN !== 1'b1) begin
            failures++; $display("FAIL abort_run3 got gnt=%b en=%b want 0001 1", GNT, CNT_EN);
        end
        REQ = 4'b0000;
`ifdef SCNTR_ARB_ABORT_EN
        step();
        checks++;
        if (CNT_PRE !== 1'b1 || GNT !== 4'b0 || ACK !== 4'b0) begin
            failures++; $display("FAIL abort_state got pre=%b gnt=%b ack=%b want 1 0000 0000", CNT_PRE, GNT, ACK);
        end
        step();
        checks++;
        if (BUSY !== 1'b0 || CNT_PRE !== 1'b0 || ACK !== 4'b0 || cnt_q !== 8'hFF) begin
            failures++; $display("FAIL abort_after got busy=%b pre=%b ack=%b q=%h want 0 0 0000 ff", BUSY, CNT_PRE, ACK, cnt_q);
        end
`else
        c_ack = -1; pre_seen = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (CNT_PRE) pre_seen++;
            if (ACK != 4'b0) begin
                checks++;
                if (ACK !== 4'b0001) begin
                    failures++; $display("FAIL noabort_ack_val got=%b want=0001", ACK);
                end
                c_ack = c;
                break;
            end
        end
        checks++;
        if (c_ack != 8 || pre_seen != 0) begin
            failures++; $display("FAIL noabort_complete got ack_cycle=%0d pre=%0d want 8 0", c_ack, pre_seen);
        end
        step();
`endif
    endtask

    task automatic test_reset_mid_run();
        int c_ack, n_gnt, n_en; int acks; logic [3:0] ack_v, gnt0; logic [7:0] d0; logic pl0;
        LDVAL = 32'h000A_0000; REQ = 4'b0100;
        step();
        REQ = 4'b0000;
        step(); step();
        RSTN = 1'b0;
        step();
        checks++;
        if (GNT !== 4'b0 || CNT_EN !== 1'b0 || ACK !== 4'b0 || BUSY !== 1'b0) begin
            failures++; $display("FAIL midrst_outputs got gnt=%b en=%b ack=%b busy=%b want 0", GNT, CNT_EN, ACK, BUSY);
        end
        RSTN = 1'b1;
        acks = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (ACK != 4'b0) acks++;
        end
        checks++;
        if (acks != 0) begin
            failures++; $display("FAIL midrst_no_ack got=%0d want=0", acks);
        end
        LDVAL = 32'h0003_0000; REQ = 4'b0100;
        run_until_ack(20, c_ack, n_gnt, n_en, ack_v, gnt0, d0, pl0);
        checks++;
        if (gnt0 !== 4'b0100 || d0 !== 8'hFD || c_ack != 5 || ack_v !== 4'b0100) begin
            failures++; $display("FAIL midrst_fresh got gnt=%b d=%h ack_cycle=%0d ack=%b want 0100 fd 5 0100",
                                 gnt0, d0, c_ack, ack_v);
        end
        step();
    endtask

    initial begin
        RSTN = 1'b0; REQ = 4'b0; LDVAL = 32'h0;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_length();
        test_abort();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
